// File: rtl/sargantana_tag_ctrl.sv
// Tag-way sequencer for the instruction cache: arbitrates sweep, refill and lookup access
// to the shared way memories, picks refill victims round-robin and resolves lookup hits.
module sargantana_tag_ctrl #(
    parameter int unsigned NUM_WAYS       = 4,
    parameter int unsigned TAG_DEPTH      = 64,
    parameter int unsigned TAG_ADDR_WIDTH = $clog2(TAG_DEPTH),
    parameter int unsigned TAG_WIDTH      = 20
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          lookup_valid_i,
    output logic                          lookup_ready_o,
    input  logic [TAG_ADDR_WIDTH-1:0]     lookup_idx_i,
    input  logic [TAG_WIDTH-1:0]          lookup_tag_i,
    output logic                          resp_valid_o,
    output logic                          resp_hit_o,
    output logic [NUM_WAYS-1:0]           resp_way_o,

    input  logic                          refill_valid_i,
    output logic                          refill_ready_o,
    input  logic [TAG_ADDR_WIDTH-1:0]     refill_idx_i,
    input  logic [TAG_WIDTH-1:0]          refill_tag_i,
    output logic [NUM_WAYS-1:0]           refill_way_o,

    input  logic                          inv_req_i,
    output logic                          inv_busy_o,
    output logic                          inv_done_o,

    output logic [NUM_WAYS-1:0]           way_req_o,
    output logic                          way_we_o,
    output logic [TAG_ADDR_WIDTH-1:0]     way_addr_o,
    output logic [TAG_WIDTH-1:0]          way_tag_o,
    output logic                          way_vbit_o,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0] way_tag_i,
    input  logic [NUM_WAYS-1:0]           way_vbit_i
);

    localparam int unsigned WayIdxW = $clog2(NUM_WAYS);

    typedef enum logic [0:0] {StRun, StInv} state_e;

    state_e                    state_q, state_d;
    logic [TAG_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [WayIdxW-1:0]        rr_q, rr_d;
    logic                      pend_q, pend_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;
    logic                      done_q, done_d;

    logic                      refill_acc;
    logic                      lookup_acc;
    logic [NUM_WAYS-1:0]       match;
    logic [NUM_WAYS-1:0]       match_low;

    assign lookup_ready_o = (state_q == StRun) & ~inv_req_i & ~refill_valid_i;
    assign refill_ready_o = (state_q == StRun) & ~inv_req_i;
    assign refill_acc     = refill_valid_i & refill_ready_o;
    assign lookup_acc     = lookup_valid_i & lookup_ready_o;
    assign refill_way_o   = NUM_WAYS'(1) << rr_q;
    assign inv_busy_o     = (state_q == StInv);
    assign inv_done_o     = done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        pend_d     = 1'b0;
        tag_d      = tag_q;
        done_d     = 1'b0;
        way_req_o  = '0;
        way_we_o   = 1'b0;
        way_addr_o = '0;
        way_tag_o  = '0;
        way_vbit_o = 1'b0;
        unique case (state_q)
            StRun: begin
                if (inv_req_i) begin
                    state_d = StInv;
                    cnt_d   = '0;
                end else if (refill_acc) begin
                    way_req_o  = refill_way_o;
                    way_we_o   = 1'b1;
                    way_vbit_o = 1'b1;
                    way_addr_o = refill_idx_i;
                    way_tag_o  = refill_tag_i;
                    rr_d = (rr_q == WayIdxW'(NUM_WAYS - 1)) ? '0 : rr_q + 1'b1;
                end else if (lookup_acc) begin
                    way_req_o  = '1;
                    way_addr_o = lookup_idx_i;
                    pend_d     = 1'b1;
                    tag_d      = lookup_tag_i;
                end
            end
            StInv: begin
                way_req_o  = '1;
                way_we_o   = 1'b1;
                way_addr_o = cnt_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == TAG_ADDR_WIDTH'(TAG_DEPTH - 1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Way memories return read data the cycle after the request, so the compare
    // happens combinationally against the tag registered at accept time.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            match[i] = way_vbit_i[i] & (way_tag_i[i*TAG_WIDTH +: TAG_WIDTH] == tag_q);
        end
    end

    assign match_low    = match & (~match + NUM_WAYS'(1));
    assign resp_valid_o = pend_q;
    assign resp_hit_o   = pend_q & (|match);
    assign resp_way_o   = pend_q ? match_low : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
            cnt_q   <= '0;
            rr_q    <= '0;
            pend_q  <= 1'b0;
            tag_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            tag_q   <= tag_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sargantana_tag_ctrl.sv
// Randomised bench for sargantana_tag_ctrl: a tag-way memory model, a set/way reference
// model and a response scoreboard drained by an independent monitor.
module tb_sargantana_tag_ctrl;

    localparam int NW = 4;
    localparam int TD = 64;
    localparam int AW = 6;
    localparam int TW = 20;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            lookup_valid_i, lookup_ready_o;
    logic [AW-1:0]   lookup_idx_i;
    logic [TW-1:0]   lookup_tag_i;
    logic            resp_valid_o, resp_hit_o;
    logic [NW-1:0]   resp_way_o;
    logic            refill_valid_i, refill_ready_o;
    logic [AW-1:0]   refill_idx_i;
    logic [TW-1:0]   refill_tag_i;
    logic [NW-1:0]   refill_way_o;
    logic            inv_req_i, inv_busy_o, inv_done_o;
    logic [NW-1:0]   way_req_o;
    logic            way_we_o;
    logic [AW-1:0]   way_addr_o;
    logic [TW-1:0]   way_tag_o;
    logic            way_vbit_o;
    logic [NW*TW-1:0] way_tag_i;
    logic [NW-1:0]   way_vbit_i;

    always #5 clk = ~clk;

    sargantana_tag_ctrl #(
        .NUM_WAYS(NW), .TAG_DEPTH(TD), .TAG_ADDR_WIDTH(AW), .TAG_WIDTH(TW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
        .lookup_idx_i(lookup_idx_i), .lookup_tag_i(lookup_tag_i),
        .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o),
        .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
        .refill_idx_i(refill_idx_i), .refill_tag_i(refill_tag_i), .refill_way_o(refill_way_o),
        .inv_req_i(inv_req_i), .inv_busy_o(inv_busy_o), .inv_done_o(inv_done_o),
        .way_req_o(way_req_o), .way_we_o(way_we_o), .way_addr_o(way_addr_o),
        .way_tag_o(way_tag_o), .way_vbit_o(way_vbit_o),
        .way_tag_i(way_tag_i), .way_vbit_i(way_vbit_i)
    );

    // Tag-way array: synchronous write, registered read.
    logic [TW-1:0] tmem [NW][TD];
    logic          vmem [NW][TD];
    logic [TW-1:0] rtag [NW];
    logic [NW-1:0] rvb;
    logic [NW-1:0] vmask;
    logic          mem_clr;

    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            if (mem_clr) begin
                for (int s = 0; s < TD; s++) begin
                    tmem[w][s] <= '0;
                    vmem[w][s] <= 1'b0;
                end
                rtag[w] <= '0;
                rvb[w]  <= 1'b0;
            end else if (way_req_o[w]) begin
                if (way_we_o) begin
                    tmem[w][way_addr_o] <= way_tag_o;
                    vmem[w][way_addr_o] <= way_vbit_o;
                end else begin
                    rtag[w] <= tmem[w][way_addr_o];
                    rvb[w]  <= vmem[w][way_addr_o];
                end
            end
        end
    end

    always_comb begin
        way_tag_i = '0;
        for (int w = 0; w < NW; w++) way_tag_i[w*TW +: TW] = rtag[w];
        way_vbit_i = rvb & vmask;
    end

    // Reference model: per-set contents, victim pointer, sweep progress.
    bit            m_v [NW][TD];
    logic [TW-1:0] m_t [NW][TD];
    int            m_rr;
    int            m_inv_left;
    bit            m_done_exp;

    typedef struct {
        int            cyc;
        bit            hit;
        logic [NW-1:0] way;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void calc(input int idx, input logic [TW-1:0] tag,
                                 output bit hit, output logic [NW-1:0] way);
        hit = 1'b0;
        way = '0;
        for (int w = 0; w < NW; w++) begin
            if (!hit && m_v[w][idx] && vmask[w] && m_t[w][idx] == tag) begin
                hit    = 1'b1;
                way[w] = 1'b1;
            end
        end
    endfunction

    task automatic drive(input bit rst, input bit inv, input bit rv, input int ridx,
                         input logic [TW-1:0] rtg, input bit lv, input int lidx,
                         input logic [TW-1:0] ltg);
        logic [NW-1:0] e_req;
        logic          e_we, e_vb, e_lr, e_rr, hit;
        logic [AW-1:0] e_addr;
        logic [TW-1:0] e_tag;
        logic [NW-1:0] way;
        @(negedge clk);
        rst_i          = rst;
        inv_req_i      = inv;
        refill_valid_i = rv;
        refill_idx_i   = AW'(ridx);
        refill_tag_i   = rtg;
        lookup_valid_i = lv;
        lookup_idx_i   = AW'(lidx);
        lookup_tag_i   = ltg;
        #1;
        chk("inv_busy", inv_busy_o, m_inv_left > 0);
        chk("inv_done", inv_done_o, m_done_exp);
        m_done_exp = 1'b0;
        chk("refill_way", refill_way_o, NW'(1) << m_rr);
        e_req = '0; e_we = 0; e_vb = 0; e_addr = '0; e_tag = '0;
        if (m_inv_left > 0) begin
            e_lr   = 0;
            e_rr   = 0;
            e_req  = '1;
            e_we   = 1;
            e_addr = AW'(TD - m_inv_left);
            for (int w = 0; w < NW; w++) m_v[w][TD - m_inv_left] = 1'b0;
            m_inv_left--;
            if (m_inv_left == 0) m_done_exp = 1'b1;
        end else begin
            e_lr = !inv && !rv;
            e_rr = !inv;
            if (inv) begin
                m_inv_left = TD;
            end else if (rv) begin
                e_req  = NW'(1) << m_rr;
                e_we   = 1;
                e_vb   = 1;
                e_addr = AW'(ridx);
                e_tag  = rtg;
                m_v[m_rr][ridx] = 1'b1;
                m_t[m_rr][ridx] = rtg;
                m_rr = (m_rr + 1) % NW;
            end else if (lv) begin
                e_req  = '1;
                e_addr = AW'(lidx);
                calc(lidx, ltg, hit, way);
                sb.push_back('{cyc + 1, hit, way});
            end
        end
        chk("lookup_ready", lookup_ready_o, e_lr);
        chk("refill_ready", refill_ready_o, e_rr);
        chk("way_if", {way_req_o, way_we_o, way_addr_o, way_tag_o, way_vbit_o},
            {e_req, e_we, e_addr, e_tag, e_vb});
        if (rst) begin
            m_inv_left = 0;
            m_rr       = 0;
            m_done_exp = 1'b0;
            sb.delete();
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, '0, 0, 0, '0);
    endtask

    task automatic refill(input int idx, input logic [TW-1:0] tag);
        drive(0, 0, 1, idx, tag, 0, 0, '0);
    endtask

    task automatic lookup(input int idx, input logic [TW-1:0] tag);
        drive(0, 0, 0, 0, '0, 1, idx, tag);
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (resp_valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_hit", resp_hit_o, e.hit);
                    chk("resp_way", resp_way_o, e.way);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                chk("resp_missing", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst_i = 1; inv_req_i = 0; refill_valid_i = 0; lookup_valid_i = 0;
        refill_idx_i = '0; refill_tag_i = '0; lookup_idx_i = '0; lookup_tag_i = '0;
        vmask = '1; mem_clr = 1;
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < TD; s++) begin m_v[w][s] = 0; m_t[w][s] = '0; end
        m_rr = 0; m_inv_left = 0; m_done_exp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 0; mem_clr = 0;
        #1;
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_resp_hit", resp_hit_o, 0);
        chk("rst_resp_way", resp_way_o, 0);
        chk("rst_busy", inv_busy_o, 0);
        chk("rst_done", inv_done_o, 0);
        chk("rst_refill_way", refill_way_o, 4'b0001);

        // Basic refill then hit.
        refill(5, 20'h12345);
        lookup(5, 20'h12345);
        idle();

        // Round-robin victim with wrap from a fresh pointer.
        drive(1, 0, 0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 4; i++) refill(3, TW'(32'hA + i));
        refill(3, 20'hE);
        lookup(3, 20'hC);
        lookup(3, 20'hE);
        lookup(3, 20'hA);

        // Refill wins over a simultaneous lookup, which then hits the new tag.
        drive(0, 0, 1, 9, 20'h777, 1, 9, 20'h777);
        lookup(9, 20'h777);
        lookup(7, 20'h55555);
        idle();
        vmask = 4'b1101;
        lookup(9, 20'h777);
        idle();
        vmask = '1;

        // Full sweep with a late lookup in flight and a mid-sweep re-request.
        lookup(5, 20'h12345);
        drive(0, 1, 0, 0, '0, 0, 0, '0);
        for (int k = 0; k < TD; k++) drive(0, k == 30, 1, 4, 20'h1, 1, 5, 20'h12345);
        lookup(5, 20'h12345);
        lookup(3, 20'hC);
        lookup(5, 20'h0);
        idle();

        // Reset during sweep cycle 10.
        refill(11, 20'h222);
        refill(12, 20'h333);
        drive(0, 1, 0, 0, '0, 0, 0, '0);
        for (int k = 0; k < 10; k++) idle();
        drive(1, 0, 0, 0, '0, 0, 0, '0);
        for (int k = 0; k < 3; k++) idle();
        lookup(12, 20'h333);
        lookup(10, 20'h0);

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            drive(0, $urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7), TW'($urandom_range(0, 5)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), TW'($urandom_range(0, 5)));
        end
        for (int k = 0; k < TD + 4; k++) idle();
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
